// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizing, drain FSM
// state encoding and the modulo helper used by the round-robin scan.
package uart_tx_arbiter_pkg;

  localparam int UART_ARB_NREQ  = 2;
  localparam int UART_ARB_DEPTH = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } uart_arb_state_e;

  // (base + offset) mod n, valid while base < n and offset <= n
  function automatic int rr_index(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read; pointers wrap naturally, so
// DEPTH must be a power of two. Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between NREQ requesters through a byte FIFO.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ  = UART_ARB_NREQ,
  parameter int DEPTH = UART_ARB_DEPTH,
  parameter int DW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    uart_start,
  output logic [DW-1:0]           uart_data,
  input  logic                    uart_busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    tx_busy
);

  localparam int IW = $clog2(NREQ);

  uart_arb_state_e state;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            push;
  logic [DW-1:0]   push_data;
  logic [DW-1:0]   fifo_rdata;
  int              idx;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_idx;
`endif

  // Scan from the highest offset down so the first valid requester in scan
  // order is the last one written and therefore wins.
  always_comb begin
    req_ready = '0;
    idx       = 0;
`ifndef UART_ARB_FIXED_PRIO_EN
    grant_idx = '0;
`endif
    if (rst_n && !fifo_full) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef UART_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = rr_index(int'(rr_ptr), k, NREQ);
`endif
        if (req_valid[IW'(idx)]) begin
          req_ready            = '0;
          req_ready[IW'(idx)]  = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          grant_idx            = IW'(idx);
`endif
        end
      end
    end
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) push_data = req_data[i*DW +: DW];
    end
  end

  assign push = |req_ready;

`ifndef UART_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    rr_ptr <= '0;
    else if (push) rr_ptr <= IW'(rr_index(int'(grant_idx), 1, NREQ));
  end
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (push_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_pop = (state == S_IDLE) && !fifo_empty && !uart_busy;

  // The serializer may raise busy a cycle late, so START/WAIT_BUSY cover that gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      uart_start <= 1'b0;
      uart_data  <= '0;
    end else begin
      uart_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            uart_data  <= fifo_rdata;
            uart_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START:     state <= uart_busy ? S_WAIT_DONE : S_WAIT_BUSY;
        S_WAIT_BUSY: if (uart_busy)  state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!uart_busy) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  assign tx_busy = (fifo_count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requester queues, a serializer model
// with configurable busy latency/duration, and hand-computed expected bytes.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              uart_start;
  logic [DW-1:0]     uart_data;
  logic              uart_busy;
  logic [CW-1:0]     fifo_count;
  logic              tx_busy;

  uart_tx_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .uart_busy  (uart_busy),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serializer model: busy rises lat_cfg cycles after a start and lasts dur_cfg cycles.
  logic       hold_busy  = 1'b0;
  logic       frame_busy = 1'b0;
  int         lat_cfg = 1;
  int         dur_cfg = 3;
  int         lat_cnt = 0;
  int         dur_cnt = 0;
  int         start_count = 0;
  logic [7:0] rx_q [$];

  assign uart_busy = hold_busy | frame_busy;

  always @(negedge clk) begin
    if (uart_start === 1'b1) begin
      check_output("start_while_busy", {31'd0, (uart_busy || lat_cnt != 0)}, 32'd0);
      rx_q.push_back(uart_data);
      start_count++;
      if (lat_cfg == 0) begin
        frame_busy = 1'b1;
        dur_cnt    = dur_cfg;
      end else begin
        lat_cnt = lat_cfg;
      end
    end else if (lat_cnt != 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        frame_busy = 1'b1;
        dur_cnt    = dur_cfg;
      end
    end else if (dur_cnt != 0) begin
      dur_cnt--;
      if (dur_cnt == 0) frame_busy = 1'b0;
    end
  end

  logic [7:0] h0_q [$];
  logic [7:0] h1_q [$];
  logic [1:0] grant_log [$];
  int         last_accept_count = 0;

  task automatic run_streams(input int budget);
    int cyc = 0;
    while ((h0_q.size() != 0 || h1_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      req_valid = {h1_q.size() != 0, h0_q.size() != 0};
      req_data  = {(h1_q.size() != 0) ? h1_q[0] : 8'h00,
                   (h0_q.size() != 0) ? h0_q[0] : 8'h00};
      #1;
      if ((req_ready & req_valid) != '0) begin
        grant_log.push_back(req_ready);
        last_accept_count = int'(fifo_count);
        if (req_ready[0]) void'(h0_q.pop_front());
        if (req_ready[1]) void'(h1_q.pop_front());
      end
      cyc++;
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_drain(input int n, input int budget);
    int cyc = 0;
    while (!(rx_q.size() >= n && !tx_busy && !uart_busy) && cyc < budget) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check_output("drain_done", {31'd0, (rx_q.size() >= n && !tx_busy && !uart_busy)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_rr [8];
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_rr = '{8'h00, 8'h22, 8'h44, 8'h66, 8'h11, 8'h33, 8'h55, 8'h77};
`else
    exp_rr = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
`endif

    // Reset: no grants while held, everything cleared afterwards
    req_valid = 2'b11;
    req_data  = 16'h1100;
    @(negedge clk); #1;
    check_output("ready_in_reset", req_ready, 2'b00);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    #1;
    check_output("reset_count", fifo_count, 0);
    check_output("reset_tx_busy", tx_busy, 0);
    check_output("reset_start", uart_start, 0);
    check_output("reset_data", uart_data, 0);

    // Same-cycle contention
    h0_q = '{8'h00};
    h1_q = '{8'h11};
    run_streams(10);
    check_output("contention_grants", grant_log.size(), 2);
    check_output("contention_grant0", grant_log[0], 2'b01);
    check_output("contention_grant1", grant_log[1], 2'b10);
    wait_drain(2, 100);
    check_output("contention_rx0", rx_q[0], 8'h00);
    check_output("contention_rx1", rx_q[1], 8'h11);

    // Round-robin fairness
    rx_q.delete();
    grant_log.delete();
    h0_q = '{8'h00, 8'h22, 8'h44, 8'h66};
    h1_q = '{8'h11, 8'h33, 8'h55, 8'h77};
    run_streams(100);
    wait_drain(8, 200);
    for (int i = 0; i < 8; i++) check_output("rr_order", rx_q[i], exp_rr[i]);

    // Full FIFO with the serializer held busy
    rx_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) h0_q.push_back(8'h80 + 8'(i));
    run_streams(12);
    check_output("full_count", fifo_count, 8);
    check_output("full_left", h0_q.size(), 1);
    req_valid = 2'b01;
    req_data  = {8'h00, 8'h88};
    #1;
    check_output("full_ready", req_ready, 2'b00);
    check_output("full_tx_busy", tx_busy, 1);
    req_valid = '0;
    hold_busy = 1'b0;
    run_streams(30);
    check_output("full_accept_after_pop", last_accept_count, 7);
    wait_drain(9, 300);
    check_output("full_rx_count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) check_output("full_order", rx_q[i], 8'h80 + 8'(i));

    // Late-busy serializer
    rx_q.delete();
    start_count = 0;
    lat_cfg = 2;
    dur_cfg = 10;
    h1_q = '{8'hC1, 8'hC2, 8'hC3};
    run_streams(20);
    wait_drain(3, 300);
    check_output("late_starts", start_count, 3);
    check_output("late_rx0", rx_q[0], 8'hC1);
    check_output("late_rx1", rx_q[1], 8'hC2);
    check_output("late_rx2", rx_q[2], 8'hC3);
    lat_cfg = 1;
    dur_cfg = 3;

    // Reset mid-operation drops queued bytes and restarts the pointer
    rx_q.delete();
    grant_log.delete();
    hold_busy = 1'b1;
    h0_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    run_streams(10);
    check_output("pre_reset_count", fifo_count, 5);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    check_output("mid_reset_ready", req_ready, 2'b00);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    hold_busy = 1'b0;
    #1;
    check_output("post_reset_count", fifo_count, 0);
    check_output("post_reset_tx_busy", tx_busy, 0);
    check_output("post_reset_start", uart_start, 0);
    check_output("post_reset_data", uart_data, 0);
    h0_q = '{8'hA5};
    h1_q = '{8'h5A};
    run_streams(10);
    check_output("post_reset_grant0", grant_log[0], 2'b01);
    wait_drain(2, 100);
    check_output("post_reset_rx_count", rx_q.size(), 2);
    check_output("post_reset_rx0", rx_q[0], 8'hA5);
    check_output("post_reset_rx1", rx_q[1], 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
